uart_rx_beat: RTL and testbench
===============================

// Module: uart_rx_beat
// PURPOSE
// - UART receive front end of mvm_uart_system: sits between the serial rx pin and the MVM core.
// - Deserialises 8N1 UART frames into bytes, then packs NUM_WORDS bytes into one wide beat.
// - Each beat (K matrix + X vector) is presented to the MVM core on a valid/ready handshake.
// - Reports framing errors and beat overruns as single-cycle pulses.
// PARAMETERS
// - CLOCKS_PER_PULSE  4   clk cycles per UART bit; even, >= 4
// - BITS_PER_WORD     8   data bits per UART frame
// - NUM_WORDS         36  words per beat; (R*C*W_K + C*W_X)/8 = (256+32)/8
// PORTS
// - clk        in   1                           system clock; all logic on rising edge
// - rst        in   1                           asynchronous, active-high reset
// - rx         in   1                           UART serial input, idle high, asynchronous to clk
// - m_data     out  NUM_WORDS*BITS_PER_WORD     packed beat; first received word in bits [BITS_PER_WORD-1:0]
// - m_valid    out  1                           beat available
// - m_ready    in   1                           consumer accepts beat when m_valid && m_ready
// - frame_err  out  1                           1-cycle pulse: stop bit sampled low
// - overrun    out  1                           1-cycle pulse: beat completed while output register occupied
// BEHAVIOUR
// - Reset (async, rst=1):
//   - m_valid=0, m_data=0, frame_err=0, overrun=0; word count=0; FSM=IDLE.
//   - Synchroniser flops preset to 1 (idle line).
// - rx passes a 2-flop synchroniser; falling-edge detection uses the synchronised signal.
// - Receiver FSM (IDLE, START, DATA, STOP); bit counter clog2(CLOCKS_PER_PULSE), data counter clog2(BITS_PER_WORD):
//   - IDLE:  synchronised rx 1->0 -> START, counter=0.
//   - START: after CLOCKS_PER_PULSE/2 cycles sample mid-bit; rx=1 -> IDLE (glitch, no error), rx=0 -> DATA.
//   - DATA:  sample every CLOCKS_PER_PULSE cycles, LSB first, BITS_PER_WORD samples -> STOP.
//   - STOP:  sample after CLOCKS_PER_PULSE cycles.
//     - rx=1 -> word accepted.
//     - rx=0 -> word discarded, frame_err pulses next cycle, word count unchanged.
//     - Either case -> IDLE. A new start edge is detected from the following cycle, so back-to-back frames are supported.
// - Packer:
//   - Accepted word is written into assembly register slot [cnt]; cnt increments.
//   - When cnt reaches NUM_WORDS-1 and a word is accepted, cnt wraps to 0 and the beat completes.
// - Output register (single entry):
//   - On beat completion, if !m_valid, or m_valid && m_ready in the same cycle:
//     - m_data <= assembled beat and m_valid=1 on the next cycle.
//     - Latency: stop-bit sample to m_valid = 2 clk.
//   - On beat completion with m_valid && !m_ready: new beat dropped, old m_data kept intact, overrun pulses, cnt still wraps to 0.
//   - m_valid && m_ready without completion -> m_valid=0 next cycle; m_data holds its last value.
//   - m_data is stable whenever m_valid=1 (AXI-stream rules); m_valid never drops without m_ready.
// - Reception never stalls on backpressure; the assembly path is independent of m_ready.
// - Reset mid-frame or mid-beat: partial word and partial beat are lost; the next falling edge after reset starts a fresh beat at slot 0.
// STRUCTURE
// - Package mvm_uart_pkg holds:
//   - the shared constants CLOCKS_PER_PULSE, BITS_PER_WORD, R, C, W_X, W_K;
//   - derived NUM_WORDS;
//   - the rx FSM state enum.
// - One sub-module uart_rx_core (synchroniser + FSM; outputs byte, byte_valid, frame_err).
// - Packer and output register live in uart_rx_beat.
// TESTING
// - Single beat: 36 frames of bytes 0x00..0x23 at 4 clk/bit, m_ready=1.
//   -> one m_valid pulse, m_data[7:0]=0x00, m_data[287:280]=0x23.
// - Framing error: frame 5 sent with stop=0.
//   -> frame_err pulses once; beat completes only after 36 good frames; the bad byte is absent from m_data.
// - Glitch: rx low for 1 clk while IDLE.
//   -> no byte accepted, no frame_err, FSM back in IDLE.
// - Backpressure: m_ready=0 across two full beats (A then B).
//   -> m_data holds A, overrun pulses once at B completion.
//   -> then m_ready=1 accepts A; a third beat C is delivered normally.
// - Accept+complete same cycle: m_ready rises in the cycle beat B completes.
//   -> A consumed, B loaded, m_valid stays 1, no overrun.
// - Mid-beat reset: rst=1 for 3 clk after 10 bytes, then send 36 bytes 0x40..0x63.
//   -> m_data[7:0]=0x40, no stale data.

Source files
------------

// File: rtl/mvm_uart_pkg.sv
// Shared constants and types for the UART receive path of mvm_uart_system.
// The beat width is derived from the MVM core geometry, so the receiver
// always packs exactly one K matrix plus one X vector per beat.
package mvm_uart_pkg;

    // Serial timing and framing
    localparam int CLOCKS_PER_PULSE = 4;   // clk cycles per UART bit, even and >= 4
    localparam int BITS_PER_WORD    = 8;   // data bits per UART frame

    // MVM core geometry
    localparam int R   = 8;                // matrix rows
    localparam int C   = 4;                // matrix columns / vector length
    localparam int W_X = 8;                // vector element width
    localparam int W_K = 8;                // matrix element width

    // One beat carries the whole K matrix followed by the X vector
    localparam int NUM_WORDS = (R * C * W_K + C * W_X) / BITS_PER_WORD;
    localparam int BEAT_W    = NUM_WORDS * BITS_PER_WORD;

    // Receiver FSM states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detection,
// mid-bit sampling FSM. Emits one-cycle byte_valid for frames with a good stop
// bit and a one-cycle frame_err for frames whose stop bit was sampled low.
module uart_rx_core
    import mvm_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLOCKS_PER_PULSE,
    parameter int DATA_BITS    = BITS_PER_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid,
    output logic                 frame_err
);

    localparam int BIT_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int DATA_CNT_W = $clog2(DATA_BITS);

    // Start bit is checked at its middle; data and stop bits one full period apart
    localparam logic [BIT_CNT_W-1:0]  HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0]  FULL_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [DATA_CNT_W-1:0] DATA_LAST = DATA_CNT_W'(DATA_BITS - 1);

    logic                  rx_meta_reg;
    logic                  rx_sync_reg;
    logic                  rx_prev_reg;
    rx_state_e             state_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_CNT_W-1:0] data_cnt_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  byte_valid_reg;
    logic                  frame_err_reg;
    logic                  start_edge;

    // Synchroniser and edge-history flops; preset high so reset looks like an idle line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign start_edge = rx_prev_reg & ~rx_sync_reg;

    // Frame FSM: qualify start bit, shift data LSB first, check stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RX_IDLE;
            bit_cnt_reg    <= '0;
            data_cnt_reg   <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    bit_cnt_reg  <= '0;
                    data_cnt_reg <= '0;
                    if (start_edge) begin
                        state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt_reg == HALF_LAST) begin
                        bit_cnt_reg <= '0;
                        // A line that is already high again was only a glitch
                        state_reg   <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_reg == FULL_LAST) begin
                        bit_cnt_reg <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
                        if (data_cnt_reg == DATA_LAST) begin
                            state_reg <= RX_STOP;
                        end else begin
                            data_cnt_reg <= data_cnt_reg + 1'b1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt_reg == FULL_LAST) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= RX_IDLE;
                        if (rx_sync_reg) begin
                            byte_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= RX_IDLE;
                end
            endcase
        end
    end

    // The shift register is only rewritten in DATA, so it is stable while byte_valid is high
    assign rx_byte    = shift_reg;
    assign byte_valid = byte_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/uart_rx_beat.sv
// UART receive front end for the MVM core. Received bytes are packed into a
// NUM_WORDS-byte beat (first byte in the lowest bits) and handed over through
// a single-entry valid/ready output register. Reception never waits on the
// consumer: a beat completing while the output register is still occupied
// is dropped and reported on overrun.
module uart_rx_beat
    import mvm_uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BEAT_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_WORDS - 1);

    logic [BITS_PER_WORD-1:0] rx_byte;
    logic                     byte_valid;
    logic [BITS_PER_WORD-1:0] slot_reg [NUM_WORDS];
    logic [BEAT_W-1:0]        assembly;
    logic [CNT_W-1:0]         word_cnt_reg;
    logic                     beat_done_reg;
    logic [BEAT_W-1:0]        m_data_reg;
    logic                     m_valid_reg;
    logic                     overrun_reg;

    uart_rx_core #(
        .CLKS_PER_BIT (CLOCKS_PER_PULSE),
        .DATA_BITS    (BITS_PER_WORD)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // One assembly slot per word; each slot loads only when the word counter points at it
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
            localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);

            // Capture the accepted byte into this slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg[gi] <= '0;
                end else if (byte_valid && (word_cnt_reg == SLOT)) begin
                    slot_reg[gi] <= rx_byte;
                end
            end

            assign assembly[gi*BITS_PER_WORD +: BITS_PER_WORD] = slot_reg[gi];
        end
    endgenerate

    // Word counter; wrapping past the last slot marks the beat as complete
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_reg  <= '0;
            beat_done_reg <= 1'b0;
        end else begin
            beat_done_reg <= 1'b0;
            if (byte_valid) begin
                if (word_cnt_reg == LAST_SLOT) begin
                    word_cnt_reg  <= '0;
                    beat_done_reg <= 1'b1;
                end else begin
                    word_cnt_reg <= word_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Single-entry output register; a full, unaccepted register keeps its beat and flags overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (beat_done_reg) begin
                if (!m_valid_reg || m_ready) begin
                    m_data_reg  <= assembly;
                    m_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_data  = m_data_reg;
    assign m_valid = m_valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_uart_rx_beat.sv
// Testbench for uart_rx_beat: serial frames are driven on rx, expected beats
// are queued as they are issued, and a monitor pops and compares on every
// m_valid && m_ready handshake.
module tb_uart_rx_beat;
    import mvm_uart_pkg::*;

    localparam int BW   = BITS_PER_WORD;
    localparam int BEAT = BEAT_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx = 1'b1;
    logic            m_ready = 1'b0;
    logic [BEAT-1:0] m_data;
    logic            m_valid;
    logic            frame_err;
    logic            overrun;

    int              checks = 0;
    int              errors = 0;
    int              beats_seen = 0;
    int              ferr_cnt = 0;
    int              ovr_cnt = 0;
    int              ferr0;
    int              ovr0;
    bit              stab_en = 1'b0;
    logic [BEAT-1:0] sb[$];
    logic [BEAT-1:0] beat_a;
    logic [BEAT-1:0] exp_beat;

    uart_rx_beat dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [BEAT-1:0] act, logic [BEAT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BEAT-1:0] make_beat(logic [7:0] base);
        logic [BEAT-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            b[i*BW +: BW] = base + 8'(i);
        end
        return b;
    endfunction

    // Align to just after a rising edge
    task automatic sync_tb();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(logic v);
        rx = v;
        repeat (CLOCKS_PER_PULSE) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; a bad stop bit is followed by an idle bit so the next start edge exists
    task automatic send_frame(logic [7:0] b, bit good_stop);
        drive_bit(1'b0);
        for (int i = 0; i < BW; i++) begin
            drive_bit(b[i]);
        end
        drive_bit(good_stop);
        if (!good_stop) begin
            drive_bit(1'b1);
        end
    endtask

    task automatic send_beat(logic [7:0] base);
        for (int i = 0; i < NUM_WORDS; i++) begin
            send_frame(base + 8'(i), 1'b1);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still pending, expected 0", sb.size());
        end
    endtask

    // Monitor: pulse counters, hold-under-backpressure rule, scoreboard compare
    initial begin
        logic            prev_valid;
        logic            prev_ready;
        logic [BEAT-1:0] prev_data;
        logic [BEAT-1:0] exp;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (stab_en && prev_valid === 1'b1 && prev_ready === 1'b0) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: m_valid=%b m_data=%0h expected m_valid=1 m_data=%0h",
                             m_valid, m_data, prev_data);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected beat: m_data=%0h with nothing expected", m_data);
                end else begin
                    exp = sb.pop_front();
                    if (m_data !== exp) begin
                        errors++;
                        $display("FAIL beat %0d: got %0h expected %0h", beats_seen, m_data, exp);
                    end else begin
                        $display("beat %0d accepted: first=%02h last=%02h", beats_seen,
                                 m_data[BW-1:0], m_data[BEAT-1 -: BW]);
                    end
                    beats_seen++;
                end
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        sync_tb();
        rst = 1'b0;
        stab_en = 1'b1;
        m_ready = 1'b1;
        repeat (5) sync_tb();

        // Single beat 0x00..0x23, with output latency check after the last frame
        sb.push_back(make_beat(8'h00));
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
            send_frame(8'(i), 1'b1);
        end
        send_frame(8'h23, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("latency m_valid low", m_valid, 0);
        @(negedge clk);
        chk("latency m_valid high", m_valid, 1);
        wait_drain();
        sync_tb();

        // Framing error on frame 5; the 36 good frames form the beat
        ferr0 = ferr_cnt;
        exp_beat = '0;
        for (int i = 0, k = 0; i < NUM_WORDS + 1; i++) begin
            if (i != 5) begin
                exp_beat[k*BW +: BW] = 8'h80 + 8'(i);
                k++;
            end
        end
        sb.push_back(exp_beat);
        for (int i = 0; i < NUM_WORDS + 1; i++) begin
            send_frame(8'h80 + 8'(i), i != 5);
        end
        wait_drain();
        chk("frame_err pulses", ferr_cnt - ferr0, 1);

        // One-clock glitch while idle must not disturb the next beat
        ferr0 = ferr_cnt;
        rx = 1'b0;
        sync_tb();
        rx = 1'b1;
        repeat (20) sync_tb();
        chk("glitch frame_err", ferr_cnt - ferr0, 0);
        chk("glitch m_valid", m_valid, 0);
        sb.push_back(make_beat(8'hC0));
        send_beat(8'hC0);
        wait_drain();

        // Backpressure across beats A and B: A held, B dropped with one overrun
        m_ready = 1'b0;
        ovr0 = ovr_cnt;
        beat_a = make_beat(8'h30);
        sb.push_back(beat_a);
        send_beat(8'h30);
        send_beat(8'h60);
        repeat (5) sync_tb();
        chk("overrun pulses", ovr_cnt - ovr0, 1);
        chk("backpressure m_valid", m_valid, 1);
        chk("backpressure m_data", m_data, beat_a);
        m_ready = 1'b1;
        wait_drain();
        sb.push_back(make_beat(8'hD0));
        send_beat(8'hD0);
        wait_drain();
        sync_tb();

        // Accept and complete in the same cycle
        m_ready = 1'b0;
        ovr0 = ovr_cnt;
        sb.push_back(make_beat(8'h05));
        send_beat(8'h05);
        sb.push_back(make_beat(8'h55));
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
            send_frame(8'h55 + 8'(i), 1'b1);
        end
        send_frame(8'h55 + 8'(NUM_WORDS - 1), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("same-cycle m_valid", m_valid, 1);
        chk("same-cycle overrun", ovr_cnt - ovr0, 0);
        wait_drain();
        sync_tb();

        // Reset after 10 bytes; next beat must start at slot 0
        for (int i = 0; i < 10; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
        end
        stab_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset m_valid", m_valid, 0);
        stab_en = 1'b1;
        sync_tb();
        sb.push_back(make_beat(8'h40));
        send_beat(8'h40);
        wait_drain();

        repeat (10) sync_tb();
        chk("beats delivered", beats_seen, 8);
        chk("total frame_err", ferr_cnt, 1);
        chk("total overrun", ovr_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
